// File: rtl/rp_dma_arbiter_pkg.sv
// rtl/rp_dma_arbiter_pkg.sv - shared types and helpers for the DMA stream arbiter
// Contents: arbiter FSM state enum, clog2 helper for parameter-derived widths,
// and the width of the truncated-packet counter.
package rp_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  localparam int TRUNC_CNT_W = 16;

  // Smallest r with (1 << r) >= v; usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rp_dma_arbiter_axis_rr_select.sv
// rtl/rp_dma_arbiter_axis_rr_select.sv - combinational round-robin pick of the next requester
// Ports:
//   cand_i   in  N   candidate mask (one bit per requester)
//   last_i   in  IW  index granted most recently
//   idx_o    out IW  first candidate found searching from last_i+1 (mod N)
//   valid_o  out 1   any candidate present
module axis_rr_select #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  cand_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic [IW-1:0] probe;

  // Walk the offsets from farthest to nearest so the nearest candidate
  // after last_i is the one left standing.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    probe   = '0;
    for (int k = N; k >= 1; k--) begin
      probe = IW'((int'(last_i) + k) % N);
      if (cand_i[probe]) begin
        idx_o   = probe;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rp_dma_arbiter.sv
// rtl/rp_dma_arbiter.sv - packet-atomic round-robin arbiter onto the shared DMA stream
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   src_enable        in  NUM_SRC   per-source arbitration enable (looked at only in IDLE)
//   s_axis_t*         in/out        NUM_SRC source streams, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_dma_t*     out/in        registered DMA output stream
//   grant             out           current or most recent granted source
//   busy              out           high while a packet is being forwarded or drained
//   trunc_count       out 16        saturating count of packets cut at MAX_BEATS
module rp_dma_arbiter
  import rp_dma_arbiter_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 128,
  parameter  int MAX_BEATS  = 128,
  localparam int GW         = clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_dma_tdata,
  output logic                          m_axis_dma_tlast,
  output logic                          m_axis_dma_tvalid,
  input  logic                          m_axis_dma_tready,
  output logic [GW-1:0]                 grant,
  output logic                          busy,
  output logic [TRUNC_CNT_W-1:0]        trunc_count
);

  localparam int BW = clog2(MAX_BEATS + 1);

  arb_state_e             state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [TRUNC_CNT_W-1:0] trunc_q, trunc_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;

  logic [GW-1:0]          rr_idx;
  logic                   rr_valid;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_valid, sel_last, sel_ready;
  logic                   accept, at_max;

  axis_rr_select #(.N(NUM_SRC), .IW(GW)) u_rr_select (
    .cand_i  (s_axis_tvalid & src_enable),
    .last_i  (last_grant_q),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  // Granted source mux and ready fan-out.
  always_comb begin
    sel_data      = '0;
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    s_axis_tready = '0;
    unique case (state_q)
      ST_LOCKED: sel_ready = !tvalid_q || m_axis_dma_tready;
      ST_DRAIN:  sel_ready = 1'b1;
      default:   sel_ready = 1'b0;
    endcase
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        sel_data         = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        s_axis_tready[i] = sel_ready;
      end
    end
  end

  assign accept = sel_valid && sel_ready;
  // This accept would be the MAX_BEATS-th beat of the packet.
  assign at_max = (beat_cnt_q == BW'(MAX_BEATS - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    trunc_d      = trunc_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;

    if (tvalid_q && m_axis_dma_tready) tvalid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          grant_d    = rr_idx;
          beat_cnt_d = '0;
          state_d    = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          tdata_d    = sel_data;
          tlast_d    = sel_last || at_max;
          tvalid_d   = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (sel_last) begin
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
            state_d      = ST_IDLE;
          end else if (at_max) begin
            if (trunc_q != '1) trunc_d = trunc_q + 1'b1;
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      trunc_q      <= '0;
      tdata_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      trunc_q      <= trunc_d;
      tdata_q      <= tdata_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
    end
  end

  assign m_axis_dma_tdata  = tdata_q;
  assign m_axis_dma_tlast  = tlast_q;
  assign m_axis_dma_tvalid = tvalid_q;
  assign grant             = grant_q;
  assign busy              = (state_q != ST_IDLE);
  assign trunc_count       = trunc_q;

endmodule

// File: tb/tb_rp_dma_arbiter.sv
// tb/tb_rp_dma_arbiter.sv - scoreboard bench for rp_dma_arbiter
module tb_rp_dma_arbiter;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int MB = 128;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS-1:0]   src_enable;
  logic [NS*DW-1:0] s_tdata;
  logic [NS-1:0]   s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tlast, m_tvalid, m_tready;
  logic [1:0]      grant;
  logic            busy;
  logic [15:0]     trunc_count;

  always #5 clk = ~clk;

  rp_dma_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .src_enable        (src_enable),
    .s_axis_tdata      (s_tdata),
    .s_axis_tlast      (s_tlast),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .m_axis_dma_tdata  (m_tdata),
    .m_axis_dma_tlast  (m_tlast),
    .m_axis_dma_tvalid (m_tvalid),
    .m_axis_dma_tready (m_tready),
    .grant             (grant),
    .busy              (busy),
    .trunc_count       (trunc_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int seq = 0;
  int out_beats = 0;
  beat_t src_q[NS][$];
  beat_t exp_q[NS][$];
  int order_q[$];
  int gaps_q[$];
  logic [NS-1:0] hs_q = '0;
  bit rand_ready = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic prev_last;
  bit in_pkt = 0;
  int cur_src = 0;
  bit rec_gaps = 0;
  bit gap_arm = 0;
  int last_tl_cycle = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue a packet on a source; with expect set, the beats it should produce
  // on the DMA port (truncated at MB with forced tlast) go to the scoreboard.
  task automatic push_pkt(input int src, input int len, input bit expect_out);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(src), 24'(seq), 32'($urandom), 32'($urandom), 32'($urandom)};
      b.last = (k == len - 1);
      src_q[src].push_back(b);
      if (expect_out && k < MB) begin
        b.last = b.last || (k == MB - 1);
        exp_q[src].push_back(b);
      end
    end
    seq++;
  endtask

  task automatic monitor();
    int s;
    beat_t e;
    s = int'(m_tdata[DW-1 -: 8]);
    out_beats++;
    check("src_id_range", 128'(s < NS), 1);
    if (s < NS) begin
      check("exp_avail", 128'(exp_q[s].size() != 0), 1);
      if (exp_q[s].size() != 0) begin
        e = exp_q[s].pop_front();
        check("out_data", m_tdata, e.data);
        check("out_last", 128'(m_tlast), 128'(e.last));
      end
    end
    if (in_pkt) check("interleave", s, cur_src);
    else cur_src = s;
    in_pkt = !m_tlast;
    if (m_tlast) order_q.push_back(s);
  endtask

  // One clock: drive at negedge, observe 1 ns later, well before the posedge.
  task automatic step();
    @(negedge clk);
    cycle++;
    for (int i = 0; i < NS; i++)
      if (hs_q[2'(i)] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    hs_q = '0;
    m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() != 0) begin
        s_tvalid[2'(i)] = 1'b1;
        s_tlast[2'(i)]  = src_q[i][0].last;
        s_tdata[i*DW +: DW] = src_q[i][0].data;
      end else begin
        s_tvalid[2'(i)] = 1'b0;
        s_tlast[2'(i)]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end
    end
    #1;
    if (prev_stall) begin
      check("stall_valid", 128'(m_tvalid), 1);
      check("stall_data", m_tdata, prev_data);
      check("stall_last", 128'(m_tlast), 128'(prev_last));
    end
    hs_q = s_tvalid & s_tready;
    for (int i = 0; i < NS; i++) begin
      if (hs_q[2'(i)] && rec_gaps) begin
        if (gap_arm) begin
          gaps_q.push_back(cycle - last_tl_cycle);
          gap_arm = 0;
        end
        if (s_tlast[2'(i)]) begin
          last_tl_cycle = cycle;
          gap_arm = 1;
        end
      end
    end
    if (m_tvalid && m_tready) monitor();
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
  endtask

  function automatic bit all_done(input logic [NS-1:0] mask);
    bit d;
    d = !busy && !m_tvalid;
    for (int i = 0; i < NS; i++) begin
      if (exp_q[i].size() != 0) d = 0;
      if (mask[2'(i)] && src_q[i].size() != 0) d = 0;
    end
    return d;
  endfunction

  task automatic drain(input logic [NS-1:0] mask, input int budget, input string tag);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = all_done(mask);
    end
    check({"drain_", tag}, 128'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, 128'(m_tvalid), 0);
    check({tag, "_tlast"}, 128'(m_tlast), 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_busy"}, 128'(busy), 0);
    check({tag, "_grant"}, 128'(grant), 0);
    check({tag, "_trunc"}, 128'(trunc_count), 0);
    check({tag, "_tready"}, 128'(s_tready), 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    src_enable = '1;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single 3-beat packet on source 2.
    push_pkt(2, 3, 1);
    step();
    check("t1_idle_busy", 128'(busy), 0);
    check("t1_idle_noready", 128'(s_tready), 0);
    step();
    check("t1_grant", 128'(grant), 2);
    check("t1_busy", 128'(busy), 1);
    check("t1_ready", 128'(s_tready), 128'(4'b0100));
    check("t1_novalid_yet", 128'(m_tvalid), 0);
    step();
    check("t1_beat0_valid", 128'(m_tvalid), 1);
    step();
    check("t1_beat1_valid", 128'(m_tvalid), 1);
    step();
    check("t1_beat2_last", 128'(m_tlast), 1);
    check("t1_busy_fall", 128'(busy), 0);
    drain('1, 50, "t1");

    // 130-beat packet on source 1: cut at 128, tail drained.
    base = out_beats;
    push_pkt(1, 130, 1);
    drain('1, 400, "trunc");
    check("trunc_beats", out_beats - base, MB);
    check("trunc_count_1", 128'(trunc_count), 1);

    // Exactly MB beats on source 3: no truncation.
    base = out_beats;
    push_pkt(3, MB, 1);
    drain('1, 400, "exact");
    check("exact_beats", out_beats - base, MB);
    check("exact_trunc_unchanged", 128'(trunc_count), 1);

    // All sources continuously valid: round-robin order and 1-cycle bubble.
    order_q.delete();
    gaps_q.delete();
    rec_gaps = 1;
    gap_arm = 0;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++) push_pkt(s, 2, 1);
    drain('1, 100, "rr");
    rec_gaps = 0;
    check("rr_pkt_count", order_q.size(), 8);
    for (int k = 0; k < order_q.size() && k < 8; k++) check("rr_order", order_q[k], k % NS);
    check("rr_gap_count", gaps_q.size(), 7);
    for (int k = 0; k < gaps_q.size(); k++) check("rr_gap", gaps_q[k], 2);

    // 1000 random packets under 50% downstream backpressure.
    rand_ready = 1;
    for (int p = 0; p < 1000; p++) push_pkt($urandom_range(0, NS - 1), $urandom_range(1, 4), 1);
    drain('1, 30000, "random");
    rand_ready = 0;

    // Disabling source 0 mid-packet lets the packet finish, then skips it.
    push_pkt(0, 6, 1);
    step();
    step();
    check("en_grant", 128'(grant), 0);
    check("en_busy", 128'(busy), 1);
    src_enable[0] = 1'b0;
    push_pkt(0, 3, 0);
    push_pkt(1, 2, 1);
    drain(4'b1110, 100, "enable");
    repeat (10) step();
    check("en_skipped", src_q[0].size(), 3);
    check("en_idle", 128'(busy), 0);

    // Reset in the middle of a packet.
    src_enable[0] = 1'b1;
    src_q[0].delete();
    push_pkt(0, 5, 1);
    repeat (4) step();
    check("mid_busy", 128'(busy), 1);
    rst_n = 1'b0;
    s_tvalid = '0;
    #1;
    check_reset_outputs("midrst");
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    hs_q = '0;
    prev_stall = 0;
    in_pkt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    order_q.delete();
    push_pkt(2, 2, 1);
    push_pkt(0, 2, 1);
    drain('1, 50, "post_reset");
    check("post_pkts", order_q.size(), 2);
    if (order_q.size() == 2) begin
      check("post_first_src0", order_q[0], 0);
      check("post_second_src2", order_q[1], 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
